bcd_conv_arbiter: RTL
=====================

# bcd_conv_arbiter

Shares one 14-bit-to-4-digit BCD conversion engine (`bcd4digit`) between two requesters, e.g. a counter display and a status display, using round-robin arbitration. It sequences the engine's start/ready handshake and holds the operand stable for the whole conversion. It blanks the stale leading digits the engine leaves behind, rejects out-of-range operands, and enforces a watchdog timeout. It sits between the value producers and the engine; its result bus feeds the display multiplexer.

## Interface
- TIMEOUT_CYC, 64: maximum engine-busy cycles before the job is aborted.
- MAX_VALUE, 9999: largest operand forwarded to the engine.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0, req1  in  1 each  request; held high until the matching ack pulse.
- val0, val1  in  14 each  operand; stable while the matching req is high.
- ack0, ack1  out  1 each  one-cycle pulse when that requester's job finishes.
- conv_start  out  1  start to the engine; registered, one-cycle pulse.
- conv_value  out  14  operand to the engine; held from grant until return to idle.
- conv_ready  in  1  engine idle flag.
- conv_a, conv_b, conv_c, conv_d  in  4 each  engine digits: ones, tens, hundreds, thousands.
- res_digits  out  16  result {thousands, hundreds, tens, ones}; held until the next result.
- res_valid  out  1  one-cycle pulse, coincident with ack.
- res_id  out  1  requester index of the current res_digits; held.
- res_err  out  1  set with res_valid when the operand is out of range or the job timed out; held.

## Operation
- States: ST_IDLE, ST_START, ST_BUSY.
- ST_IDLE: a grant requires at least one req high.
  - If only one req is high, that requester is granted.
  - If both are high, the requester not served last is granted. The last-served pointer resets to 1, so req0 wins the first tie.
  - Operand > MAX_VALUE: no conversion. Same cycle as the decision: res_digits=16'hEEEE, res_err=1, res_valid and ack pulse, pointer updates. Stay in ST_IDLE. This path does not require conv_ready.
  - Operand in range and conv_ready=1: latch the operand into conv_value, set conv_start=1, go to ST_START.
  - Operand in range and conv_ready=0: no grant; wait.
- ST_START: conv_start is high for exactly this cycle. At the next edge, conv_start=0 and go to ST_BUSY. Clear the watchdog counter.
- ST_BUSY: conv_ready is low after the engine accepts start. Increment the watchdog each cycle.
  - conv_ready=1: capture digits with blanking, res_err=0, pulse res_valid and ack, update the pointer, go to ST_IDLE.
  - Watchdog reaches TIMEOUT_CYC: res_digits=16'hEEEE, res_err=1, pulse res_valid and ack, go to ST_IDLE. The next grant waits for conv_ready.
- Blanking uses the latched operand: < 10 forces tens, hundreds and thousands to 4'hF; < 100 forces hundreds and thousands to 4'hF; < 1000 forces thousands to 4'hF. The ones digit is never blanked.
- A requester that drops req mid-job is still acked; the job completes normally.
- A requester must not reassert req in the cycle its ack is high. The earliest re-request is the cycle after ack.

## Timing
- Reset values: ack0=ack1=0, conv_start=0, conv_value=0, res_digits=16'hFFFF, res_valid=0, res_id=0, res_err=0, state ST_IDLE, pointer=1.
- rst mid-job aborts immediately. No ack or res_valid is issued for the aborted job.
- Latency, in-range operand: grant edge → conv_start high 1 cycle → ST_BUSY → result 1 cycle after the first conv_ready=1 sampled in ST_BUSY.
- Latency, out-of-range operand: ack 1 cycle after req is sampled.
- Throughput: at most one job in flight. Back-to-back requesters are served alternately.
- All outputs are registered. No combinational path from any input to any output.

## Structure
- Shared package bcd_pkg:
  - state encoding;
  - BCD_BLANK=4'hF, BCD_ERR=4'hE;
  - MAX_VALUE;
  - digit bundle typedef (4×4 bits).
- One sub-module: bcd_blank_mask, combinational. Inputs are the 14-bit operand and 16-bit raw digits; output is the 16-bit blanked digits. It is reusable by other display paths.
- The round-robin pointer, FSM and watchdog stay in the top module.

## Test plan
- req0 alone with val0=1234, behavioural engine model → conv_start single pulse with conv_value=1234; res_digits=16'h1234, res_id=0, res_err=0, one ack0 pulse.
- req1 with val1=7, engine returning digits with stale high digits (e.g. preloaded 9s) → res_digits=16'hFFF7. Repeat with 0 → 16'hFFF0, and with 100 → 16'hF100.
- req0 and req1 asserted in the same cycle after reset, val0=42, val1=9999 → req0 served first (16'hFF42), then req1 (16'h9999). Repeated ties alternate.
- val0=10000 → no conv_start; ack0 the next cycle with res_digits=16'hEEEE and res_err=1.
- Engine held busy (conv_ready=0) for more than 64 cycles → ack with 16'hEEEE and res_err=1. The next request is not granted until conv_ready=1.
- rst pulsed during ST_BUSY → all outputs return to their reset values and no ack is issued. A subsequent req0 with val0=56 completes normally with 16'hFF56.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_pkg                                                   |
// | Brief    : Shared types and constants for the BCD conversion path:   |
// |            arbiter state encoding, digit codes, operand range and    |
// |            the four-digit result bundle.                             |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package bcd_pkg;

  // Arbiter states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  // Operand width accepted by the conversion engine
  localparam int OPERAND_W = 14;

  // Largest operand the engine can represent in four decimal digits
  localparam int MAX_VALUE = 9999;

  // Digit codes outside 0-9: blank drives a dark segment, err shows "E"
  localparam logic [3:0] BCD_BLANK = 4'hF;
  localparam logic [3:0] BCD_ERR   = 4'hE;

  // Four BCD digits, most significant first so the packed vector reads
  // {thousands, hundreds, tens, ones}
  typedef struct packed {
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_digits_t;

  localparam bcd_digits_t DIGITS_BLANK = {4{BCD_BLANK}};
  localparam bcd_digits_t DIGITS_ERR   = {4{BCD_ERR}};

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_blank_mask.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_blank_mask                                            |
// | Brief    : Replaces leading-zero digit positions with the blank      |
// |            code, based on the magnitude of the operand that produced |
// |            them. The engine may leave stale values in those          |
// |            positions, so the raw digits are never trusted there.     |
// |            The ones digit is always shown.                           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module bcd_blank_mask
  import bcd_pkg::*;
(
  input  logic [OPERAND_W-1:0] operand,
  input  logic [15:0]          raw_digits,
  output logic [15:0]          blanked_digits
);

  bcd_digits_t w_digits;

  // Blank every position above the operand's most significant decimal digit
  always_comb begin
    w_digits = raw_digits;
    if (operand < 14'd10) begin
      w_digits.tens      = BCD_BLANK;
      w_digits.hundreds  = BCD_BLANK;
      w_digits.thousands = BCD_BLANK;
    end else if (operand < 14'd100) begin
      w_digits.hundreds  = BCD_BLANK;
      w_digits.thousands = BCD_BLANK;
    end else if (operand < 14'd1000) begin
      w_digits.thousands = BCD_BLANK;
    end
  end

  assign blanked_digits = w_digits;

endmodule : bcd_blank_mask
`default_nettype wire

// File: rtl/bcd_conv_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_conv_arbiter                                          |
// | Brief    : Round-robin sharing of one 4-digit BCD conversion engine  |
// |            between two requesters. Handles the engine start/ready    |
// |            handshake, holds the operand for the whole job, rejects   |
// |            out-of-range operands, blanks leading digits and aborts   |
// |            jobs that exceed a watchdog limit. All outputs registered.|
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int MAX_VALUE   = bcd_pkg::MAX_VALUE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [OPERAND_W-1:0] val0,
  input  logic [OPERAND_W-1:0] val1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 conv_start,
  output logic [OPERAND_W-1:0] conv_value,
  input  logic                 conv_ready,
  input  logic [3:0]           conv_a,
  input  logic [3:0]           conv_b,
  input  logic [3:0]           conv_c,
  input  logic [3:0]           conv_d,
  output logic [15:0]          res_digits,
  output logic                 res_valid,
  output logic                 res_id,
  output logic                 res_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [OPERAND_W-1:0] c_max_operand = OPERAND_W'(MAX_VALUE);
  // Abort on the cycle the count would reach TIMEOUT_CYC
  localparam logic [WD_W-1:0]      c_wd_last     = WD_W'(TIMEOUT_CYC - 1);

  // Registered state
  state_t                 r_state;
  logic                   r_last;      // requester served most recently
  logic                   r_job_id;    // requester owning the job in flight
  logic [WD_W-1:0]        r_wdog;
  logic                   r_ack0;
  logic                   r_ack1;
  logic                   r_conv_start;
  logic [OPERAND_W-1:0]   r_conv_value;
  bcd_digits_t            r_res_digits;
  logic                   r_res_valid;
  logic                   r_res_id;
  logic                   r_res_err;

  // Next-state values
  state_t                 w_nxt_state;
  logic                   w_nxt_last;
  logic                   w_nxt_job_id;
  logic [WD_W-1:0]        w_nxt_wdog;
  logic                   w_nxt_ack0;
  logic                   w_nxt_ack1;
  logic                   w_nxt_conv_start;
  logic [OPERAND_W-1:0]   w_nxt_conv_value;
  bcd_digits_t            w_nxt_res_digits;
  logic                   w_nxt_res_valid;
  logic                   w_nxt_res_id;
  logic                   w_nxt_res_err;

  // Arbitration helpers
  logic                   w_req_any;
  logic                   w_gnt_id;
  logic [OPERAND_W-1:0]   w_gnt_val;
  logic                   w_gnt_oor;
  logic [15:0]            w_raw_digits;
  logic [15:0]            w_blanked;

  // On a tie the requester not served last wins; otherwise the lone requester
  assign w_req_any    = req0 | req1;
  assign w_gnt_id     = (req0 & req1) ? ~r_last : req1;
  assign w_gnt_val    = w_gnt_id ? val1 : val0;
  assign w_gnt_oor    = (w_gnt_val > c_max_operand);
  assign w_raw_digits = {conv_d, conv_c, conv_b, conv_a};

  // Blanking keys off the latched operand, not the live requester value
  bcd_blank_mask u_blank_mask (
    .operand        (r_conv_value),
    .raw_digits     (w_raw_digits),
    .blanked_digits (w_blanked)
  );

  // Next-state and registered-output decode
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_last       = r_last;
    w_nxt_job_id     = r_job_id;
    w_nxt_wdog       = r_wdog;
    w_nxt_ack0       = 1'b0;
    w_nxt_ack1       = 1'b0;
    w_nxt_conv_start = 1'b0;
    w_nxt_conv_value = r_conv_value;
    w_nxt_res_digits = r_res_digits;
    w_nxt_res_valid  = 1'b0;
    w_nxt_res_id     = r_res_id;
    w_nxt_res_err    = r_res_err;

    case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          if (w_gnt_oor) begin
            // Rejected without touching the engine, so conv_ready is irrelevant
            w_nxt_res_digits = DIGITS_ERR;
            w_nxt_res_err    = 1'b1;
            w_nxt_res_valid  = 1'b1;
            w_nxt_res_id     = w_gnt_id;
            w_nxt_ack0       = ~w_gnt_id;
            w_nxt_ack1       = w_gnt_id;
            w_nxt_last       = w_gnt_id;
          end else if (conv_ready) begin
            w_nxt_conv_value = w_gnt_val;
            w_nxt_conv_start = 1'b1;
            w_nxt_job_id     = w_gnt_id;
            w_nxt_state      = ST_START;
          end
        end
      end

      ST_START: begin
        w_nxt_wdog  = '0;
        w_nxt_state = ST_BUSY;
      end

      ST_BUSY: begin
        if (conv_ready) begin
          w_nxt_res_digits = w_blanked;
          w_nxt_res_err    = 1'b0;
          w_nxt_res_valid  = 1'b1;
          w_nxt_res_id     = r_job_id;
          w_nxt_ack0       = ~r_job_id;
          w_nxt_ack1       = r_job_id;
          w_nxt_last       = r_job_id;
          w_nxt_state      = ST_IDLE;
        end else if (r_wdog == c_wd_last) begin
          w_nxt_res_digits = DIGITS_ERR;
          w_nxt_res_err    = 1'b1;
          w_nxt_res_valid  = 1'b1;
          w_nxt_res_id     = r_job_id;
          w_nxt_ack0       = ~r_job_id;
          w_nxt_ack1       = r_job_id;
          w_nxt_last       = r_job_id;
          w_nxt_state      = ST_IDLE;
        end else begin
          w_nxt_wdog = r_wdog + 1'b1;
        end
      end

      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any job with no ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last       <= 1'b1;
      r_job_id     <= 1'b0;
      r_wdog       <= '0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_conv_start <= 1'b0;
      r_conv_value <= '0;
      r_res_digits <= DIGITS_BLANK;
      r_res_valid  <= 1'b0;
      r_res_id     <= 1'b0;
      r_res_err    <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_last       <= w_nxt_last;
      r_job_id     <= w_nxt_job_id;
      r_wdog       <= w_nxt_wdog;
      r_ack0       <= w_nxt_ack0;
      r_ack1       <= w_nxt_ack1;
      r_conv_start <= w_nxt_conv_start;
      r_conv_value <= w_nxt_conv_value;
      r_res_digits <= w_nxt_res_digits;
      r_res_valid  <= w_nxt_res_valid;
      r_res_id     <= w_nxt_res_id;
      r_res_err    <= w_nxt_res_err;
    end
  end

  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign conv_start = r_conv_start;
  assign conv_value = r_conv_value;
  assign res_digits = r_res_digits;
  assign res_valid  = r_res_valid;
  assign res_id     = r_res_id;
  assign res_err    = r_res_err;

endmodule : bcd_conv_arbiter
`default_nettype wire
